// File: rtl/mem_dump_arbiter.sv
// Shares the data-memory port between the pipeline MEM stage and a debug dump engine.
// The pipeline always wins; the dump engine reads words 0..N_WORDS-1 only on idle cycles.
module mem_dump_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_WORDS    = 32,
    parameter logic [1:0]  SIZE_WORD  = 2'b11
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_pipe_read,
    input  logic                  i_pipe_write,
    input  logic                  i_pipe_signed,
    input  logic [1:0]            i_pipe_size,
    input  logic [DATA_WIDTH-1:0] i_pipe_address,
    input  logic [DATA_WIDTH-1:0] i_pipe_datawrite,
    output logic [DATA_WIDTH-1:0] o_pipe_dataread,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_busy,
    output logic                  o_dump_done,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_signed,
    output logic [1:0]            o_mem_size,
    output logic [DATA_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_datawrite,
    input  logic [DATA_WIDTH-1:0] i_mem_dataread
);

    localparam int unsigned CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_count, w_count_next;
    logic [DATA_WIDTH-1:0] r_data, w_data_next;
    logic                  w_pipe_req;
    logic [DATA_WIDTH-1:0] w_dump_addr;

    assign w_pipe_req  = i_pipe_read | i_pipe_write;
    assign w_dump_addr = DATA_WIDTH'({r_count, 2'b00});

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_data_next  = r_data;
        unique case (r_state)
            StIdle: begin
                if (i_dump_start) begin
                    w_count_next = '0;
                    w_state_next = StRead;
                end
            end
            StRead: begin
                // Pipeline owns the port this cycle: stall without capturing.
                if (!w_pipe_req) begin
                    w_data_next  = i_mem_dataread;
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (i_dump_ready) begin
                    if (r_count == LAST) begin
                        w_state_next = StDone;
                    end else begin
                        w_count_next = r_count + CW'(1);
                        w_state_next = StRead;
                    end
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_signed    = 1'b0;
        o_mem_size      = 2'b00;
        o_mem_address   = '0;
        o_mem_datawrite = '0;
        if (w_pipe_req) begin
            o_mem_read      = i_pipe_read;
            o_mem_write     = i_pipe_write;
            o_mem_signed    = i_pipe_signed;
            o_mem_size      = i_pipe_size;
            o_mem_address   = i_pipe_address;
            o_mem_datawrite = i_pipe_datawrite;
        end else if (r_state == StRead) begin
            o_mem_read    = 1'b1;
            o_mem_size    = SIZE_WORD;
            o_mem_address = w_dump_addr;
        end
    end

    assign o_pipe_dataread = i_mem_dataread;
    assign o_dump_valid    = (r_state == StSend);
    assign o_dump_data     = r_data;
    assign o_dump_busy     = (r_state != StIdle);
    assign o_dump_done     = (r_state == StDone);

endmodule

// File: tb/tb_mem_dump_arbiter.sv
// Self-checking bench for mem_dump_arbiter with N_WORDS=4 and a behavioural word memory.
module tb_mem_dump_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          i_reset;
    logic          i_pipe_read, i_pipe_write, i_pipe_signed;
    logic [1:0]    i_pipe_size;
    logic [DW-1:0] i_pipe_address, i_pipe_datawrite;
    logic [DW-1:0] o_pipe_dataread;
    logic          i_dump_start, i_dump_ready;
    logic          o_dump_valid, o_dump_busy, o_dump_done;
    logic [DW-1:0] o_dump_data;
    logic          o_mem_read, o_mem_write, o_mem_signed;
    logic [1:0]    o_mem_size;
    logic [DW-1:0] o_mem_address, o_mem_datawrite;
    logic [DW-1:0] i_mem_dataread;

    logic [DW-1:0] mem [16];
    logic          preload;

    int n_checks = 0;
    int n_fail   = 0;

    mem_dump_arbiter #(
        .DATA_WIDTH(DW),
        .N_WORDS   (4),
        .SIZE_WORD (2'b11)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_pipe_read     (i_pipe_read),
        .i_pipe_write    (i_pipe_write),
        .i_pipe_signed   (i_pipe_signed),
        .i_pipe_size     (i_pipe_size),
        .i_pipe_address  (i_pipe_address),
        .i_pipe_datawrite(i_pipe_datawrite),
        .o_pipe_dataread (o_pipe_dataread),
        .i_dump_start    (i_dump_start),
        .i_dump_ready    (i_dump_ready),
        .o_dump_valid    (o_dump_valid),
        .o_dump_data     (o_dump_data),
        .o_dump_busy     (o_dump_busy),
        .o_dump_done     (o_dump_done),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_mem_signed    (o_mem_signed),
        .o_mem_size      (o_mem_size),
        .o_mem_address   (o_mem_address),
        .o_mem_datawrite (o_mem_datawrite),
        .i_mem_dataread  (i_mem_dataread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_mem_dataread = mem[o_mem_address[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (o_mem_write) begin
            mem[o_mem_address[5:2]] <= o_mem_datawrite;
        end
    end

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_rd;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        tick();
    endtask

    // Runs with ready high until the done pulse is sampled, bounded by max cycles.
    task automatic run_to_done(input string name, input int max);
        logic seen;
        seen = 1'b0;
        i_dump_ready = 1'b1;
        for (int i = 0; i < max; i++) begin
            tick();
            #1;
            if (o_dump_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
        tick();
        #1 chk({name, "_idle"}, {31'd0, o_dump_busy}, 32'd0);
    endtask

    initial begin
        int words, dones;

        i_reset = 1'b0;
        preload = 1'b0;
        i_pipe_read = 1'b0; i_pipe_write = 1'b0; i_pipe_signed = 1'b0;
        i_pipe_size = 2'b00; i_pipe_address = '0; i_pipe_datawrite = '0;
        i_dump_start = 1'b0; i_dump_ready = 1'b0;

        #1;
        chk("rst_valid", {31'd0, o_dump_valid}, 32'd0);
        chk("rst_busy",  {31'd0, o_dump_busy},  32'd0);
        chk("rst_done",  {31'd0, o_dump_done},  32'd0);
        chk("rst_data",  o_dump_data, 32'd0);
        chk("rst_mem",   {o_mem_read, o_mem_write, o_mem_signed, o_mem_size}, 32'd0);
        chk("rst_addr",  o_mem_address, 32'd0);
        tick();
        tick();
        i_reset = 1'b1;
        do_preload();

        // Basic dump, ready tied high: done lands 9 cycles after the start cycle.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h8};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hC};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};

        for (int k = 0; k < 11; k++) begin
            i_dump_start = vecs[k].start;
            i_dump_ready = vecs[k].ready;
            #1;
            chk($sformatf("vec%0d_valid", k), {31'd0, o_dump_valid}, {31'd0, vecs[k].exp_valid});
            chk($sformatf("vec%0d_busy", k),  {31'd0, o_dump_busy},  {31'd0, vecs[k].exp_busy});
            chk($sformatf("vec%0d_done", k),  {31'd0, o_dump_done},  {31'd0, vecs[k].exp_done});
            chk($sformatf("vec%0d_rd", k),    {31'd0, o_mem_read},   {31'd0, vecs[k].exp_rd});
            chk($sformatf("vec%0d_addr", k),  o_mem_address, vecs[k].exp_addr);
            if (vecs[k].exp_valid) chk($sformatf("vec%0d_data", k), o_dump_data, vecs[k].exp_data);
            tick();
        end

        // Backpressure on word 1.
        do_preload();
        i_dump_start = 1'b1; i_dump_ready = 1'b0;
        tick();
        i_dump_start = 1'b0;
        tick();
        #1 chk("bp_w0_valid", {31'd0, o_dump_valid}, 32'd1);
        i_dump_ready = 1'b1;
        tick();
        i_dump_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_valid", {31'd0, o_dump_valid}, 32'd1);
            chk("bp_hold_data", o_dump_data, 32'hA000_0001);
            tick();
        end
        i_dump_ready = 1'b1;
        #1 chk("bp_release_valid", {31'd0, o_dump_valid}, 32'd1);
        tick();
        #1 chk("bp_next_addr", o_mem_address, 32'h8);
        run_to_done("bp_done", 20);

        // Pipeline write stalls READ of word 2; pipeline read during SEND.
        do_preload();
        i_dump_start = 1'b1; i_dump_ready = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        i_pipe_write = 1'b1; i_pipe_size = 2'b11;
        i_pipe_address = 32'h8; i_pipe_datawrite = 32'hDEAD_BEEF;
        #1;
        chk("pri_write", {31'd0, o_mem_write}, 32'd1);
        chk("pri_read",  {31'd0, o_mem_read},  32'd0);
        chk("pri_addr",  o_mem_address, 32'h8);
        chk("pri_wdata", o_mem_datawrite, 32'hDEAD_BEEF);
        chk("pri_size",  {30'd0, o_mem_size}, 32'd3);
        tick();
        i_pipe_write = 1'b0; i_pipe_address = '0; i_pipe_datawrite = '0; i_pipe_size = 2'b00;
        #1;
        chk("pri_stall_valid", {31'd0, o_dump_valid}, 32'd0);
        chk("pri_resume_rd", {31'd0, o_mem_read}, 32'd1);
        chk("pri_resume_addr", o_mem_address, 32'h8);
        tick();
        i_dump_ready = 1'b0;
        i_pipe_read = 1'b1; i_pipe_address = 32'h4;
        #1;
        chk("pri_w2_data", o_dump_data, 32'hDEAD_BEEF);
        chk("psend_rdata", o_pipe_dataread, 32'hA000_0001);
        chk("psend_valid", {31'd0, o_dump_valid}, 32'd1);
        tick();
        i_pipe_read = 1'b0; i_pipe_address = '0;
        #1 chk("psend_hold", o_dump_data, 32'hDEAD_BEEF);
        run_to_done("pri_done", 20);

        // Start pulses while busy are ignored; pipe access in the start cycle is served.
        do_preload();
        words = 0;
        dones = 0;
        i_dump_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_dump_start = (i == 0 || i == 4 || i == 9);
            i_pipe_read = (i == 0);
            i_pipe_address = (i == 0) ? 32'hC : 32'h0;
            #1;
            if (i == 0) begin
                chk("sb_pipe_rdata", o_pipe_dataread, 32'hA000_0003);
                chk("sb_pipe_addr", o_mem_address, 32'hC);
            end
            if (o_dump_valid && i_dump_ready) begin
                chk("sb_word", o_dump_data, 32'hA000_0000 + 32'(words));
                words++;
            end
            if (o_dump_done) dones++;
            tick();
        end
        i_dump_start = 1'b0; i_pipe_read = 1'b0;
        chk("sb_words", 32'(words), 32'd4);
        chk("sb_dones", 32'(dones), 32'd1);

        // Asynchronous reset while word 1 is being offered.
        do_preload();
        i_dump_start = 1'b1; i_dump_ready = 1'b0;
        tick();
        i_dump_start = 1'b0;
        tick();
        i_dump_ready = 1'b1;
        tick();
        i_dump_ready = 1'b0;
        tick();
        #1 chk("ar_pre_data", o_dump_data, 32'hA000_0001);
        #2 i_reset = 1'b0;
        #1;
        chk("ar_valid", {31'd0, o_dump_valid}, 32'd0);
        chk("ar_busy",  {31'd0, o_dump_busy},  32'd0);
        chk("ar_done",  {31'd0, o_dump_done},  32'd0);
        tick();
        tick();
        i_reset = 1'b1;
        i_dump_start = 1'b1; i_dump_ready = 1'b1;
        #1 chk("ar_idle", {31'd0, o_dump_busy}, 32'd0);
        tick();
        i_dump_start = 1'b0;
        #1 chk("ar_restart_addr", o_mem_address, 32'h0);
        tick();
        #1 chk("ar_restart_data", o_dump_data, 32'hA000_0000);
        run_to_done("ar_done_after", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_dump_arbiter.md
Name: mem_dump_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage and a debug dump engine.
- The dump engine reads N_WORDS consecutive words from byte address 0 and streams each word to the debug/UART transmitter over a valid/ready handshake.
- The pipeline always has priority; the dump engine only uses the memory port in cycles the pipeline leaves idle.
- Sits between MEM and the data memory, with its dump side feeding the debug unit.

Parameters:
- DATA_WIDTH, 32, data and address width.
- N_WORDS, 32, number of words dumped; must be ≥ 1.
- SIZE_WORD, 2'b11, size-field encoding driven to memory for a full-word access.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_pipe_read  in  1  pipeline memory read request.
- i_pipe_write  in  1  pipeline memory write request.
- i_pipe_signed  in  1  pipeline signed-load flag.
- i_pipe_size  in  2  pipeline access size.
- i_pipe_address  in  DATA_WIDTH  pipeline byte address.
- i_pipe_datawrite  in  DATA_WIDTH  pipeline store data.
- o_pipe_dataread  out  DATA_WIDTH  read data returned to the pipeline.
- i_dump_start  in  1  one-cycle pulse that starts a dump.
- i_dump_ready  in  1  debug transmitter can accept a word.
- o_dump_valid  out  1  o_dump_data is valid.
- o_dump_data  out  DATA_WIDTH  dumped word.
- o_dump_busy  out  1  a dump is in progress.
- o_dump_done  out  1  one-cycle pulse when the dump completes.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_mem_signed  out  1  memory signed flag.
- o_mem_size  out  2  memory access size.
- o_mem_address  out  DATA_WIDTH  memory byte address.
- o_mem_datawrite  out  DATA_WIDTH  memory store data.
- i_mem_dataread  in  DATA_WIDTH  memory read data; combinational with respect to the address.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE, word counter=0, data register=0.
  - o_dump_valid=0, o_dump_busy=0, o_dump_done=0.
  - Memory-side outputs follow the combinational mux below, so with pipeline inputs low they are all 0.
- Port mux (combinational):
  - pipe_req = i_pipe_read | i_pipe_write.
  - If pipe_req=1: all o_mem_* come from the pipe_* inputs.
  - Else, if state==READ: o_mem_read=1, o_mem_write=0, o_mem_signed=0, o_mem_size=SIZE_WORD, o_mem_address=counter*4, o_mem_datawrite=0.
  - Otherwise all o_mem_* are 0.
  - o_pipe_dataread=i_mem_dataread at all times.
- FSM states: IDLE, READ, SEND, DONE.
  - IDLE: i_dump_start=1 → counter=0, go to READ.
  - READ: if pipe_req=0, capture i_mem_dataread into the data register and go to SEND. If pipe_req=1, stay in READ (stall) with no capture. The stall has no timeout.
  - SEND: o_dump_valid=1 and o_dump_data=data register. Data is held stable while valid && !ready.
    - On i_dump_ready=1 with counter==N_WORDS-1 → go to DONE.
    - On i_dump_ready=1 otherwise → counter+1, go to READ.
    - The pipeline may access memory freely during SEND.
  - DONE: o_dump_done=1 for exactly one cycle, then go to IDLE.
- o_dump_busy=1 in READ, SEND and DONE.
- Latency per word with no contention and ready tied high: READ→SEND takes 1 cycle and the handshake completes in the SEND cycle, i.e. 2 cycles per word. A full dump takes 2*N_WORDS + 1 cycles from the start pulse to the done pulse.
- i_dump_start outside IDLE is ignored; no restart and no queueing.
- Counter width is clog2(N_WORDS) (minimum 1 bit). The counter never wraps, because termination happens at N_WORDS-1.
- Reset asserted mid-dump aborts immediately: o_dump_valid=0 and no done pulse is issued.
- A pipeline access in the same cycle as i_dump_start is served normally; the dump enters READ on the next edge.

Test Plan:
- Basic dump: preload mem[i]=0xA0000000+i, N_WORDS=4, ready held 1, pulse start. Expect data 0xA0000000..0xA0000003 in order, each with valid=1. Expect done pulse at cycle 9 after start, and busy low afterwards.
- Backpressure: hold ready=0 for 5 cycles while the word at index 1 is valid. Expect valid to stay 1 and data to stay at 0xA0000001 with the counter frozen; the transfer completes when ready=1.
- Pipeline priority: assert i_pipe_write to address 0x8 with data 0xDEADBEEF during READ of word 2. Expect the memory port to show the pipe address/data with write=1. The dump stalls, then reads 0xDEADBEEF as word 2.
- Pipeline read during SEND: pipe read of address 0x4. Expect o_pipe_dataread=mem[1] in the same cycle, and o_dump_data unchanged.
- Start while busy: pulse start mid-dump. Expect no restart; exactly N_WORDS words and a single done pulse.
- Async reset mid-dump: drop i_reset while in SEND. Expect valid, busy and done to go 0 immediately without waiting for a clock edge. After release, a new start dumps again from word 0.
